// File: rtl/mem_io_responder_if.sv
// CPU byte-bus, UART RX/TX and status signals shared by the memory-side responder and its master.
interface mem_io_responder_if;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        prog_stop;
  logic        addr_err;

  modport slave (
    input  cpu_a, cpu_dout, cpu_wr, rx_data, rx_valid, tx_ready,
    output cpu_din, io_buffer_full, rx_ready, tx_data, tx_valid, prog_stop, addr_err
  );

  modport master (
    output cpu_a, cpu_dout, cpu_wr, rx_data, rx_valid, tx_ready,
    input  cpu_din, io_buffer_full, rx_ready, tx_data, tx_valid, prog_stop, addr_err
  );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder: byte RAM, I/O window (UART RX/TX, cycle counter, program stop), TX FIFO.
// Optional feature macro: MEM_IO_BOUNDS_CHECK_EN (flags and blocks out-of-range RAM accesses).
module mem_io_responder #(
  parameter int RAM_ADDR_W = 17,
  parameter int TX_DEPTH   = 8
) (
  input logic               clk_in,
  input logic               rst_in,
  mem_io_responder_if.slave bus
);
  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(TX_DEPTH);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(TX_DEPTH - 1);

  logic [7:0]       r_ram [2**RAM_ADDR_W];
  logic [7:0]       r_fifo [TX_DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_cycleCnt;
  logic [31:0]      r_snapshot;
  logic [7:0]       r_din;
  logic             r_full;
  logic             r_progStop;

  logic                  w_io;
  logic [2:0]            w_ioOff;
  logic [RAM_ADDR_W-1:0] w_ramIdx;
  logic                  w_oob;
  logic                  w_ramWr;
  logic                  w_ioWr;
  logic                  w_pushReq;
  logic [7:0]            w_pushData;
  logic                  w_push;
  logic                  w_pop;
  logic [CNT_W-1:0]      w_countNext;

  assign w_io     = (bus.cpu_a[17:16] == 2'b11);
  assign w_ioOff  = bus.cpu_a[2:0];
  assign w_ramIdx = bus.cpu_a[RAM_ADDR_W-1:0];

`ifdef MEM_IO_BOUNDS_CHECK_EN
  logic r_addrErr;
  assign w_oob = !w_io && (bus.cpu_a[31:RAM_ADDR_W] != '0);
  always_ff @(posedge clk_in) begin
    if (rst_in)
      r_addrErr <= 1'b0;
    else if (w_oob)
      r_addrErr <= 1'b1;
  end
  assign bus.addr_err = r_addrErr;
`else
  // Upper address bits are deliberately ignored so the RAM aliases.
  logic [13:0] w_unusedHi;
  assign w_unusedHi   = bus.cpu_a[31:18];
  assign w_oob        = 1'b0;
  assign bus.addr_err = 1'b0;
`endif

  assign w_ramWr = bus.cpu_wr && !w_io && !w_oob;
  assign w_ioWr  = bus.cpu_wr && w_io && !r_progStop;

  always_comb begin
    w_pushReq  = 1'b0;
    w_pushData = 8'h00;
    if (w_ioWr) begin
      if (w_ioOff == 3'd0 && bus.cpu_dout != 8'h00) begin
        w_pushReq  = 1'b1;
        w_pushData = bus.cpu_dout;
      end else if (w_ioOff == 3'd4) begin
        w_pushReq  = 1'b1;
        w_pushData = 8'h00;
      end
    end
  end

  // A pop in the same cycle frees the slot a push to a full FIFO needs.
  assign w_pop  = (r_count != '0) && bus.tx_ready;
  assign w_push = w_pushReq && ((r_count < DEPTH_C) || w_pop);

  always_comb begin
    w_countNext = r_count;
    if (w_push && !w_pop)
      w_countNext = r_count + CNT_W'(1);
    else if (!w_push && w_pop)
      w_countNext = r_count - CNT_W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (w_ramWr)
      r_ram[w_ramIdx] <= bus.cpu_dout;
    if (w_push)
      r_fifo[r_wrPtr] <= w_pushData;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_din      <= 8'h00;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_cycleCnt <= 32'h0;
      r_snapshot <= 32'h0;
      r_progStop <= 1'b0;
    end else begin
      r_cycleCnt <= r_cycleCnt + 32'h1;
      if (w_push)
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      r_count <= w_countNext;
      r_full  <= (w_countNext >= FULL_LVL);
      if (w_ioWr && w_ioOff == 3'd4)
        r_progStop <= 1'b1;
      if (!bus.cpu_wr) begin
        if (w_io) begin
          // Offset 4 snapshots the counter so bytes 1..3 read back coherently.
          case (w_ioOff)
            3'd0: r_din <= bus.rx_valid ? bus.rx_data : 8'h00;
            3'd4: begin
              r_snapshot <= r_cycleCnt;
              r_din      <= r_cycleCnt[7:0];
            end
            3'd5:    r_din <= r_snapshot[15:8];
            3'd6:    r_din <= r_snapshot[23:16];
            3'd7:    r_din <= r_snapshot[31:24];
            default: r_din <= 8'h00;
          endcase
        end else if (w_oob) begin
          r_din <= 8'hFF;
        end else begin
          r_din <= r_ram[w_ramIdx];
        end
      end
    end
  end

  assign bus.rx_ready       = !rst_in && w_io && !bus.cpu_wr && (w_ioOff == 3'd0) && bus.rx_valid;
  assign bus.cpu_din        = r_din;
  assign bus.io_buffer_full = r_full;
  assign bus.tx_data        = r_fifo[r_rdPtr];
  assign bus.tx_valid       = (r_count != '0);
  assign bus.prog_stop      = r_progStop;
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed and randomized bench for mem_io_responder against a queue/array reference model.
module tb_mem_io_responder;
  localparam int RAM_ADDR_W = 17;
  localparam int TX_DEPTH   = 8;

  logic clk_in = 1'b0;
  logic rst_in;
  mem_io_responder_if bus();

  mem_io_responder #(.RAM_ADDR_W(RAM_ADDR_W), .TX_DEPTH(TX_DEPTH)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  int nChecks = 0;
  int nPass   = 0;

  logic [7:0]  mRam [int];
  logic [7:0]  mFifo [$];
  logic [7:0]  txLog [$];
  logic [31:0] mCycle = 32'h0;
  logic [31:0] mSnap  = 32'h0;
  logic [7:0]  mDin   = 8'h00;
  bit          mDinKnown = 1'b0;
  bit          mStop = 1'b0;
  bit          mFull = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: advances the abstract state by one clock edge using the current inputs.
  function automatic void modelEdge();
    logic [31:0] a;
    bit          io;
    int          idx;
    bit          pop;
    bit          pushReq;
    bit          accept;
    logic [7:0]  pushByte;
    a   = bus.cpu_a;
    io  = (a[17:16] == 2'b11);
    idx = int'(a[16:0]);
    if (rst_in) begin
      mFifo.delete();
      mCycle = 0; mSnap = 0; mStop = 0; mFull = 0; mDin = 0; mDinKnown = 1;
      return;
    end
    pop      = (mFifo.size() > 0) && bus.tx_ready;
    pushReq  = 0;
    pushByte = 8'h00;
    if (bus.cpu_wr) begin
      if (io) begin
        if (!mStop && a[2:0] == 3'd0 && bus.cpu_dout != 8'h00) begin
          pushReq = 1; pushByte = bus.cpu_dout;
        end else if (!mStop && a[2:0] == 3'd4) begin
          pushReq = 1; pushByte = 8'h00; mStop = 1;
        end
      end else begin
        mRam[idx] = bus.cpu_dout;
      end
    end else begin
      mDinKnown = 1;
      if (io) begin
        case (a[2:0])
          3'd0: mDin = bus.rx_valid ? bus.rx_data : 8'h00;
          3'd4: begin mSnap = mCycle; mDin = mCycle[7:0]; end
          3'd5: mDin = mSnap[15:8];
          3'd6: mDin = mSnap[23:16];
          3'd7: mDin = mSnap[31:24];
          default: mDin = 8'h00;
        endcase
      end else if (mRam.exists(idx)) begin
        mDin = mRam[idx];
      end else begin
        mDinKnown = 0;
      end
    end
    accept = pushReq && ((mFifo.size() < TX_DEPTH) || pop);
    if (pop) void'(mFifo.pop_front());
    if (accept) mFifo.push_back(pushByte);
    mCycle = mCycle + 1;
    mFull  = (mFifo.size() >= TX_DEPTH - 1);
  endfunction

  task automatic runCycle();
    logic [31:0] a;
    #1;
    a = bus.cpu_a;
    checkOutput("rx_ready", 32'(bus.rx_ready),
                32'(!rst_in && a[17:16] == 2'b11 && !bus.cpu_wr && a[2:0] == 3'd0 && bus.rx_valid));
    if (bus.tx_valid && bus.tx_ready) txLog.push_back(bus.tx_data);
    modelEdge();
    @(posedge clk_in);
    #1;
    if (mDinKnown) checkOutput("cpu_din", 32'(bus.cpu_din), 32'(mDin));
    checkOutput("tx_valid", 32'(bus.tx_valid), 32'(mFifo.size() > 0));
    if (mFifo.size() > 0) checkOutput("tx_data", 32'(bus.tx_data), 32'(mFifo[0]));
    checkOutput("io_buffer_full", 32'(bus.io_buffer_full), 32'(mFull));
    checkOutput("prog_stop", 32'(bus.prog_stop), 32'(mStop));
    checkOutput("addr_err", 32'(bus.addr_err), 32'h0);
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic wr, input logic [7:0] dout);
    bus.cpu_a    = a;
    bus.cpu_wr   = wr;
    bus.cpu_dout = dout;
    runCycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(32'h0003_0001, 1'b0, 8'h00);
  endtask

  task automatic doReset();
    rst_in = 1'b1;
    applyStimulus(32'h0003_0001, 1'b0, 8'h00);
    rst_in = 1'b0;
  endtask

  function automatic logic [31:0] ramAddr(input logic [16:0] idx);
    logic [31:0] a;
    a = $urandom;
    a[16:0] = idx;
    if (a[17:16] == 2'b11) a[17] = 1'b0;
    return a;
  endfunction

  logic [16:0] pool [8];
  logic [31:0] snapVal;

  initial begin
    rst_in       = 1'b1;
    bus.cpu_a    = 32'h0003_0001;
    bus.cpu_dout = 8'h00;
    bus.cpu_wr   = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;

    // Reset state
    doReset();
    checkOutput("reset_cpu_din", 32'(bus.cpu_din), 32'h0);
    checkOutput("reset_tx_valid", 32'(bus.tx_valid), 32'h0);
    checkOutput("reset_full", 32'(bus.io_buffer_full), 32'h0);

    // RAM write then read-after-write
    applyStimulus(32'h0000_0010, 1'b1, 8'hA5);
    applyStimulus(32'h0000_0010, 1'b0, 8'h00);
    checkOutput("ram_raw", 32'(bus.cpu_din), 32'hA5);

    // TX: zero byte at offset 0 is skipped
    bus.tx_ready = 1'b1;
    txLog.delete();
    applyStimulus(32'h0003_0000, 1'b1, 8'h48);
    applyStimulus(32'h0003_0000, 1'b1, 8'h00);
    applyStimulus(32'h0003_0000, 1'b1, 8'h69);
    idle(4);
    checkOutput("tx_seq_len", 32'(txLog.size()), 32'd2);
    if (txLog.size() == 2) begin
      checkOutput("tx_seq_0", 32'(txLog[0]), 32'h48);
      checkOutput("tx_seq_1", 32'(txLog[1]), 32'h69);
    end

    // FIFO fill, almost-full flag, overflow drop, drain
    bus.tx_ready = 1'b0;
    txLog.delete();
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(32'h0003_0000, 1'b1, 8'h41);
      if (i == 6) checkOutput("full_after6", 32'(bus.io_buffer_full), 32'h0);
      if (i == 7) checkOutput("full_after7", 32'(bus.io_buffer_full), 32'h1);
    end
    bus.tx_ready = 1'b1;
    idle(12);
    checkOutput("drain_count", 32'(txLog.size()), 32'd8);
    checkOutput("drain_full_clr", 32'(bus.io_buffer_full), 32'h0);

    // Cycle counter snapshot coherence
    doReset();
    idle(100);
    snapVal = 32'h0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(32'h0003_0004 + 32'(k), 1'b0, 8'h00);
      snapVal[8*k +: 8] = bus.cpu_din;
    end
    checkOutput("snap_in_range", 32'(snapVal >= 32'd100 && snapVal <= 32'd104), 32'h1);
    checkOutput("snap_exact", snapVal, 32'd100);

    // UART RX read
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h7A;
    bus.cpu_a    = 32'h0003_0000;
    bus.cpu_wr   = 1'b0;
    #1;
    checkOutput("rx_ready_pulse", 32'(bus.rx_ready), 32'h1);
    runCycle();
    checkOutput("rx_data_read", 32'(bus.cpu_din), 32'h7A);
    bus.cpu_a = 32'h0003_0001;
    #1;
    checkOutput("rx_ready_drop", 32'(bus.rx_ready), 32'h0);
    runCycle();
    bus.rx_valid = 1'b0;
    applyStimulus(32'h0003_0000, 1'b0, 8'h00);
    checkOutput("rx_empty_read", 32'(bus.cpu_din), 32'h0);

    // Program stop
    txLog.delete();
    bus.tx_ready = 1'b0;
    applyStimulus(32'h0003_0004, 1'b1, 8'h55);
    checkOutput("stop_tx_byte", 32'(bus.tx_data), 32'h00);
    checkOutput("stop_tx_valid", 32'(bus.tx_valid), 32'h1);
    checkOutput("stop_flag", 32'(bus.prog_stop), 32'h1);
    bus.tx_ready = 1'b1;
    applyStimulus(32'h0003_0000, 1'b1, 8'h41);
    idle(3);
    checkOutput("stop_log_len", 32'(txLog.size()), 32'd1);
    applyStimulus(32'h0000_0010, 1'b0, 8'h00);
    checkOutput("stop_ram_ok", 32'(bus.cpu_din), 32'hA5);
    doReset();
    checkOutput("stop_cleared", 32'(bus.prog_stop), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 8; i++) begin
      pool[i] = 17'($urandom);
      applyStimulus(ramAddr(pool[i]), 1'b1, 8'($urandom));
    end
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [31:0] a;
      logic [2:0]  off;
      logic        wr;
      r = $urandom_range(0, 99);
      bus.rx_valid = 1'($urandom);
      bus.rx_data  = 8'($urandom);
      bus.tx_ready = ((i / 100) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      if (r < 2) begin
        doReset();
      end else if (r < 30) begin
        applyStimulus(ramAddr(pool[$urandom_range(0, 7)]), 1'b1, 8'($urandom));
      end else if (r < 55) begin
        applyStimulus(ramAddr(pool[$urandom_range(0, 7)]), 1'b0, 8'($urandom));
      end else begin
        off = 3'($urandom_range(0, 7));
        wr  = 1'($urandom);
        if (wr && off == 3'd4 && $urandom_range(0, 7) != 0) off = 3'd0;
        a = $urandom;
        a[17:16] = 2'b11;
        a[2:0]   = off;
        applyStimulus(a, wr, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
      end
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
